// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx
//   Receives the device-clocked PS/2 mouse stream and checks each 11-bit frame
//   (start, 8 data bits LSB first, odd parity, stop). It assembles standard
//   3-byte packets and presents them as qzt-synchronous outputs.
// Ports
//   qzt        : system clock, the only clock in this block
//   rst        : asynchronous, active-high reset
//   ps2_clk    : raw PS/2 clock pin (asynchronous to qzt)
//   ps2_data   : raw PS/2 data pin (asynchronous to qzt)
//   btn_left/btn_right/btn_middle : button levels from the last valid packet
//   dx, dy     : 9-bit signed motion from the last valid packet
//   ovf        : {Y overflow, X overflow} from the last valid packet
//   pkt_valid  : one-cycle pulse; the outputs above change in the same cycle
//   frame_err  : one-cycle pulse on a start, parity, stop or timeout error
module ps2_mouse_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       qzt,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [1:0] ovf,
  output logic       pkt_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic          clk_f_q, clk_f_d;
  logic [FW-1:0] flt_q, flt_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    byte0_q, byte0_d, byte1_q, byte1_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0]    btn_q, btn_d;
  logic [8:0]    dx_q, dx_d, dy_q, dy_d;
  logic [1:0]    ovf_q, ovf_d;
  logic          pkt_q, pkt_d, err_q, err_d;
  logic          fall;

  // Two-flop synchronisers. They reset to the idle-high line level so that
  // leaving reset does not look like a clock edge.
  always_ff @(posedge qzt or posedge rst) begin
    if (rst) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
    end
  end

  always_comb begin
    clk_f_d   = clk_f_q;
    flt_d     = '0;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    idx_d     = idx_q;
    byte0_d   = byte0_q;
    byte1_d   = byte1_q;
    tmo_d     = tmo_q;
    btn_d     = btn_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    ovf_d     = ovf_q;
    pkt_d     = 1'b0;
    err_d     = 1'b0;
    fall      = 1'b0;

    // The glitch filter flips clk_f after FILTER_LEN consecutive samples that
    // disagree with it. A 1->0 flip is the bit strobe.
    if (clk_sync_q != clk_f_q) begin
      if (flt_q == FW'(FILTER_LEN - 1)) begin
        clk_f_d = clk_sync_q;
        fall    = clk_f_q;
      end else begin
        flt_d = flt_q + 1'b1;
      end
    end

    if (fall) begin
      // A strobe always beats a timeout that expires in the same cycle.
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (!dat_sync_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_sync_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_sync_q && (^{shift_q, par_q})) begin
            unique case (idx_q)
              2'd0: begin
                // Byte 0 always has bit 3 set. Anything else is dropped so
                // the receiver can find the packet boundary again.
                if (shift_q[3]) begin
                  byte0_d = shift_q;
                  idx_d   = 2'd1;
                end
              end
              2'd1: begin
                byte1_d = shift_q;
                idx_d   = 2'd2;
              end
              2'd2: begin
                btn_d = byte0_q[2:0];
                dx_d  = {byte0_q[4], byte1_q};
                dy_d  = {byte0_q[5], shift_q};
                ovf_d = {byte0_q[7], byte0_q[6]};
                pkt_d = 1'b1;
                idx_d = 2'd0;
              end
              default: idx_d = 2'd0;
            endcase
          end else begin
            err_d = 1'b1;
            idx_d = 2'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE || idx_q != 2'd0) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
        err_d   = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge qzt or posedge rst) begin
    if (rst) begin
      clk_f_q   <= 1'b1;
      flt_q     <= '0;
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      idx_q     <= '0;
      byte0_q   <= '0;
      byte1_q   <= '0;
      tmo_q     <= '0;
      btn_q     <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      ovf_q     <= '0;
      pkt_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      clk_f_q   <= clk_f_d;
      flt_q     <= flt_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      idx_q     <= idx_d;
      byte0_q   <= byte0_d;
      byte1_q   <= byte1_d;
      tmo_q     <= tmo_d;
      btn_q     <= btn_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      ovf_q     <= ovf_d;
      pkt_q     <= pkt_d;
      err_q     <= err_d;
    end
  end

  assign btn_left   = btn_q[0];
  assign btn_right  = btn_q[1];
  assign btn_middle = btn_q[2];
  assign dx         = dx_q;
  assign dy         = dy_q;
  assign ovf        = ovf_q;
  assign pkt_valid  = pkt_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx. The PS/2 clock runs faster and the timeout is
// shorter than in the real system so that the run stays short.
module tb_ps2_mouse_rx;

  localparam int HALF = 20;    // qzt cycles per PS/2 clock half-period
  localparam int TMO  = 2000;

  typedef struct {
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] ovf;
  } pkt_t;

  logic       qzt = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       btn_left, btn_right, btn_middle;
  logic [8:0] dx, dy;
  logic [1:0] ovf;
  logic       pkt_valid, frame_err;

  int   checks = 0;
  int   failures = 0;
  int   err_cnt = 0;
  int   pkt_cnt = 0;
  int   e0, p0;
  pkt_t exp_q[$];
  pkt_t mon_e;
  logic [8:0] dx_snap;

  ps2_mouse_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .qzt(qzt), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .btn_left(btn_left), .btn_right(btn_right), .btn_middle(btn_middle),
    .dx(dx), .dy(dy), .ovf(ovf), .pkt_valid(pkt_valid), .frame_err(frame_err)
  );

  always #10 qzt = ~qzt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    pkt_t p;
    p.btn = b0[2:0];
    p.dx  = {b0[4], b1};
    p.dy  = {b0[5], b2};
    p.ovf = {b0[7], b0[6]};
    return p;
  endfunction

  // Output monitor. It samples on the falling qzt edge, away from the active edge.
  always @(negedge qzt) begin
    if (frame_err) err_cnt++;
    if (pkt_valid) begin
      pkt_cnt++;
      check("pv_err_excl", {31'd0, frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pkt", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("btn", {29'd0, btn_middle, btn_right, btn_left}, {29'd0, mon_e.btn});
        check("dx", {23'd0, dx}, {23'd0, mon_e.dx});
        check("dy", {23'd0, dy}, {23'd0, mon_e.dy});
        check("ovf", {30'd0, ovf}, {30'd0, mon_e.ovf});
      end
    end
  end

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (HALF) @(posedge qzt);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge qzt);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(posedge qzt);
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    send_bits(b, bad_par, 11);
    repeat (2 * HALF) @(posedge qzt);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_q.push_back(mk(b0, b1, b2));
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge qzt);
    #1;
    check(tag, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_btn"}, {29'd0, btn_middle, btn_right, btn_left}, 32'd0);
    check({tag, "_dx"}, {23'd0, dx}, 32'd0);
    check({tag, "_dy"}, {23'd0, dy}, 32'd0);
    check({tag, "_ovf"}, {30'd0, ovf}, 32'd0);
    check({tag, "_pv"}, {31'd0, pkt_valid}, 32'd0);
    check({tag, "_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    repeat (5) @(posedge qzt);
    #1;
    check_zero("reset");
    @(posedge qzt);
    rst = 1'b0;
    repeat (20) @(posedge qzt);

    // Basic packet
    e0 = err_cnt; p0 = pkt_cnt;
    send_pkt(8'h29, 8'h05, 8'hFB);
    drain("t1_drain");
    check("t1_pkts", pkt_cnt - p0, 1);
    check("t1_errs", err_cnt - e0, 0);
    check("t1_hold_dy", {23'd0, dy}, 32'h1FB);

    // Bad parity on byte 1 aborts that packet
    e0 = err_cnt; p0 = pkt_cnt;
    send_byte(8'h08, 1'b0);
    send_byte(8'h10, 1'b1);
    check("t2_errs_a", err_cnt - e0, 1);
    check("t2_pkts_a", pkt_cnt - p0, 0);
    send_pkt(8'h0A, 8'h10, 8'h00);
    drain("t2_drain");
    check("t2_pkts", pkt_cnt - p0, 1);
    check("t2_errs", err_cnt - e0, 1);

    // Stray byte without bit 3 is dropped silently
    e0 = err_cnt; p0 = pkt_cnt;
    send_byte(8'h01, 1'b0);
    send_pkt(8'h09, 8'h05, 8'h29);
    drain("t3_drain");
    check("t3_pkts", pkt_cnt - p0, 1);
    check("t3_errs", err_cnt - e0, 0);

    // Partial packet then silence: timeout
    e0 = err_cnt; p0 = pkt_cnt;
    send_byte(8'h08, 1'b0);
    send_bits(8'h55, 1'b0, 7);
    repeat (TMO + 500) @(posedge qzt);
    #1;
    check("t4_tmo_errs", err_cnt - e0, 1);
    check("t4_tmo_pkts", pkt_cnt - p0, 0);
    send_pkt(8'hC8, 8'h7F, 8'h80);
    drain("t4_drain");
    check("t4_pkts", pkt_cnt - p0, 1);
    check("t4_errs", err_cnt - e0, 1);

    // Short glitch on ps2_clk while idle
    e0 = err_cnt; p0 = pkt_cnt;
    dx_snap = dx;
    @(posedge qzt);
    ps2_clk = 1'b0;
    repeat (3) @(posedge qzt);
    ps2_clk = 1'b1;
    repeat (50) @(posedge qzt);
    #1;
    check("t5_glitch_errs", err_cnt - e0, 0);
    check("t5_glitch_pkts", pkt_cnt - p0, 0);
    check("t5_hold_dx", {23'd0, dx}, {23'd0, dx_snap});
    send_pkt(8'h0C, 8'h01, 8'h02);
    drain("t5_drain");
    check("t5_pkts", pkt_cnt - p0, 1);
    check("t5_errs", err_cnt - e0, 0);

    // Reset during byte 2
    e0 = err_cnt; p0 = pkt_cnt;
    send_byte(8'h09, 1'b0);
    send_byte(8'h22, 1'b0);
    send_bits(8'h33, 1'b0, 5);
    @(posedge qzt);
    #3 rst = 1'b1;
    #1;
    check_zero("t6_rst");
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(posedge qzt);
    rst = 1'b0;
    repeat (20) @(posedge qzt);
    #1;
    check("t6_rst_pkts", pkt_cnt - p0, 0);
    check("t6_rst_errs", err_cnt - e0, 0);
    send_pkt(8'h39, 8'h80, 8'h01);
    drain("t6_drain");
    check("t6_pkts", pkt_cnt - p0, 1);
    check("t6_errs", err_cnt - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
